// File: rtl/flag_sync_pkg.sv
// Purpose: shared FSM encoding and default parameters for the flag_sync dispatch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flag_sync_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_WAIT_CLR  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo_19.sv
// Purpose: small in-order FIFO with registered occupancy; head word readable combinationally.
// Latency: a word pushed at edge k is visible at the head after edge k.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo_19
    import flag_sync_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage array: written at the tail; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); simultaneous push+pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/flag_sync_dispatch_19.sv
// Purpose: buffers words and issues them one at a time to the flag-sync stage, capturing results.
// Latency: push at edge k -> trigger after edge k+1; result slot valid one cycle after done sampled.
// Backpressure: in_ready drops when FIFO full; no issue while result slot occupied or done still high.
module flag_sync_dispatch_19
    import flag_sync_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   sync_trigger,
    output logic [DATA_W-1:0]      sync_data,
    input  logic                   sync_done,
    input  logic [DATA_W-1:0]      sync_result,
    output logic                   res_valid,
    output logic [DATA_W-1:0]      res_data,
    input  logic                   res_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_timeout
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_issue;
    logic                w_capture;
    logic                w_abort;
    logic [DATA_W-1:0]   w_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [TW-1:0]       r_timer;
    logic                r_trigger;
    logic [DATA_W-1:0]   r_sync_data;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_busy;
    logic                r_err;

    sync_fifo_19 #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (in_valid),
        .i_push_data (in_data),
        .i_pop       (w_issue),
        .o_pop_data  (w_head),
        .o_count     (fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign in_ready     = !w_fifo_full;
    assign sync_trigger = r_trigger;
    assign sync_data    = r_sync_data;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign busy         = r_busy;
    assign err_timeout  = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: issue only when the stage has dropped done and the result slot is free.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !r_res_valid && !sync_done) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Done wins over a coincident timeout.
                if (sync_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WAIT_CLR;
                end else if (r_timer == TMO_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_CLR: begin
                if (!sync_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Trigger pulse, issued word, timeout timer, result slot and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trigger   <= 1'b0;
            r_sync_data <= '0;
            r_timer     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_trigger <= w_issue;
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_issue) begin
                r_sync_data <= w_head;
                r_timer     <= '0;
            end else if (r_state == ST_WAIT_DONE) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_capture) begin
                r_res_data  <= sync_result;
                r_res_valid <= 1'b1;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
